load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Bridges the core's load/store request to the byte-enabled, word-organised data memory (combinational read, 4-bit per-byte write enable, write on rising CLK).
- Checks alignment and funct3 legality.
- Generates byte-lane write enables and replicates store data onto the lanes.
- Extracts and sign/zero-extends load data.
- Returns each result through a registered, one-cycle response pulse.

Parameters:
None. Data and address width are fixed at 32.

Ports:
CLK  input  1  system clock, rising edge
RESET_N  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
mem_addr  output  32  address to memory, bits [1:0] forced to 0
mem_wd  output  32  lane-replicated store data
mem_we  output  4  byte write enables; bit i writes bits [8i+7:8i]
mem_rd  input  32  combinational read word from memory
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  extended load result (0 for stores and errors)
resp_err  output  1  misaligned or illegal request; no memory access performed

Behaviour:
Clock and reset:
- One clock, CLK. RESET_N is asynchronous, active-low.
- While RESET_N=0: state=IDLE, all latched request registers=0, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.

FSM states IDLE, ACCESS, DONE:
- IDLE: req_ready=1, mem_we=0.
  - On a rising edge with req_valid=1, latch we/funct3/addr/wdata.
  - Legal and aligned request -> ACCESS.
  - Otherwise -> DONE with resp_err=1, resp_rdata=0.
- ACCESS: req_ready=0. mem_addr={addr[31:2],2'b00}. mem_we=mask if store, else 4'b0000.
  - Store: the memory commits at the edge that leaves ACCESS.
  - Load: mem_rd is sampled at that same edge; the extracted value is registered into resp_rdata and resp_err=0.
  - Next state -> DONE.
- DONE: resp_valid=1 for exactly this one cycle; resp_rdata/resp_err hold their registered values. Next state -> IDLE.
- resp_rdata/resp_err hold their values until the next response overwrites them.

Latency and throughput:
- Request accepted at edge N; ACCESS during cycle N+1; resp_valid high during cycle N+2.
- Error requests skip ACCESS: resp_valid high in cycle N+1.
- Throughput is one request per 3 cycles (per 2 for errors). req_valid outside IDLE is ignored and not queued.

Legality and alignment:
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. All other codes are illegal.
- Halfword accesses require addr[0]=0; word accesses require addr[1:0]=00. Byte accesses are always aligned.

Store lanes (o = addr[1:0]):
- SB: mem_wd={4{wdata[7:0]}}, mask=4'b0001<<o.
- SH: mem_wd={2{wdata[15:0]}}, mask=4'b0011<<o.
- SW: mem_wd=wdata, mask=4'b1111.
- mem_wd is driven from the latched data in every state; it is only meaningful when mem_we≠0.

Load extract:
- s = mem_rd >> (8*o).
- LB: sign-extend s[7:0]. LBU: zero-extend s[7:0].
- LH: sign-extend s[15:0]. LHU: zero-extend s[15:0].
- LW: mem_rd unchanged.
- Stores: resp_rdata=0.

Reset mid-operation:
- RESET_N falling during ACCESS forces mem_we=0 immediately, so no write commits; the request is dropped and no resp_valid is produced.
- RESET_N falling during DONE clears resp_valid immediately.

Test Plan:
- SW addr=0x10 wdata=0xDEADBEEF -> in ACCESS mem_addr=0x10, mem_we=4'b1111, mem_wd=0xDEADBEEF; resp_valid 2 cycles after accept, resp_rdata=0, resp_err=0.
- SB addr=0x11 wdata=0x123456AB -> mem_we=4'b0010, mem_wd=0xABABABAB, mem_addr=0x10; memory word 0x00000000 becomes 0x0000AB00.
- Word at 0x10 = 0x80FF7F01 -> LB 0x13 gives 0xFFFFFF80; LBU 0x13 gives 0x00000080; LH 0x12 gives 0xFFFF80FF; LHU 0x12 gives 0x000080FF; LB 0x11 gives 0x0000007F.
- LW addr=0x06, then SH addr=0x03, then funct3=3'b011 load -> each gives resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, mem_we=0 throughout.
- req_valid held high continuously with back-to-back LWs -> req_ready high only in IDLE; one response per 3 cycles; no request lost or duplicated.
- SW addr=0x20 wdata=0xCAFEF00D, RESET_N driven low mid-ACCESS before the write edge -> mem_we=0 immediately; memory word unchanged; no resp_valid; after release, req_ready=1.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: bridges a core load/store request onto a byte-enabled,
// word-organised data memory. It checks funct3 legality and alignment,
// steers store data onto the byte lanes, and extends load data. Each request
// produces a one-cycle registered response pulse.
//
// Ports
//   CLK, RESET_N              clock (rising edge), async active-low reset
//   req_valid/req_ready       request handshake (ready only while idle)
//   req_we, req_funct3        store/load select, RV32I load/store funct3
//   req_addr, req_wdata       byte address, right-aligned store data
//   mem_addr, mem_wd, mem_we  word address, lane-replicated data, byte enables
//   mem_rd                    combinational read word from memory
//   resp_valid/rdata/err      response pulse, extended load data, error flag
module load_store_unit (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_rd,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // latched request fields needed after the accept edge
  logic       we_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;

  logic             legal_c, aligned_c, ok_c;
  logic [LANES-1:0] mask_c;
  logic [XLEN-1:0]  wd_c;
  logic [HALF_W-1:0] shifted_c;
  logic [XLEN-1:0]  ext_c;

  // next values of the registered outputs
  logic             req_ready_d, resp_valid_d, resp_err_d;
  logic [XLEN-1:0]  resp_rdata_d, mem_addr_d, mem_wd_d;
  logic [LANES-1:0] mem_we_d;

  // Request decode: legality, alignment, byte-lane mask and replicated data.
  always_comb begin
    legal_c   = 1'b0;
    aligned_c = 1'b1;
    mask_c    = 4'b1111;
    wd_c      = req_wdata;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal_c = 1'b1;
      3'b100, 3'b101:         legal_c = ~req_we;
      default:                legal_c = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00: begin
        mask_c = 4'(4'b0001 << req_addr[1:0]);
        wd_c   = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        aligned_c = ~req_addr[0];
        mask_c    = 4'(4'b0011 << req_addr[1:0]);
        wd_c      = {2{req_wdata[15:0]}};
      end
      default: aligned_c = (req_addr[1:0] == 2'b00);
    endcase
    ok_c = legal_c & aligned_c;
  end

  // Load extract: bring the addressed byte/halfword down to bit 0, then extend.
  always_comb begin
    shifted_c = HALF_W'(mem_rd >> {off_q, 3'b000});
    case (f3_q)
      3'b000:  ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
      3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c};
      3'b100:  ext_c = {24'd0, shifted_c[7:0]};
      3'b101:  ext_c = {16'd0, shifted_c};
      default: ext_c = mem_rd;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; errors skip ACCESS.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = ok_c ? S_ACCESS : S_DONE;
      S_ACCESS: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err;
    resp_rdata_d = resp_rdata;
    mem_we_d     = 4'b0000;
    mem_addr_d   = mem_addr;
    mem_wd_d     = mem_wd;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          mem_addr_d = {req_addr[31:2], 2'b00};
          mem_wd_d   = wd_c;
          if (ok_c) begin
            if (req_we) mem_we_d = mask_c;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end
        end
      end
      S_ACCESS: begin
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        resp_rdata_d = we_q ? '0 : ext_c;
      end
      default: ;
    endcase
  end

  // Output and request-latch registers; reset drops any write in flight.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_we     <= '0;
      mem_addr   <= '0;
      mem_wd     <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
    end else begin
      req_ready  <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_err   <= resp_err_d;
      resp_rdata <= resp_rdata_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wd     <= mem_wd_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q  <= req_we;
        f3_q  <= req_funct3;
        off_q <= req_addr[1:0];
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: a word memory model driven by the DUT, a
// byte-array reference model, directed vector table, handshake/reset
// sequences and a randomized phase.
module tb_load_store_unit;

  logic        CLK;
  logic        RESET_N;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [3:0]  mem_we;
  logic [31:0] mem_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  load_store_unit dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Data memory seen by the DUT: combinational read, byte-enabled write.
  logic [31:0] mem [256];
  logic        mem_clear;
  assign mem_rd = mem[mem_addr[9:2]];

  always @(posedge CLK) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (mem_we[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  // Reference memory as plain bytes.
  logic [7:0] ref_mem [1024];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: apply one request to the byte memory and predict the response.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic err,
                            output logic [31:0] rdata, output logic [3:0] mask,
                            output logic [31:0] wd);
    int size;
    logic legal;
    logic [31:0] v;
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    err   = !legal || ((addr % 32'(size)) != 0);
    rdata = '0;
    mask  = '0;
    wd    = '0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < size; b++) ref_mem[10'(addr + 32'(b))] = wdata[8*b +: 8];
        mask = 4'(((32'd1 << size) - 32'd1) << (addr % 32'd4));
        for (int k = 0; k < 4; k++) wd[8*k +: 8] = wdata[8*(k % size) +: 8];
      end else begin
        v = '0;
        for (int b = 0; b < size; b++) v[8*b +: 8] = ref_mem[10'(addr + 32'(b))];
        if (!f3[2] && size < 4 && v[8*size-1]) v = v - (32'd1 << (8*size));
        rdata = v;
      end
    end
  endtask

  // Issue one request and capture what the DUT does with it.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic err,
                         output logic [31:0] rdata, output logic [3:0] mask,
                         output logic [31:0] maddr, output logic [31:0] wd,
                         output int lat, output logic after);
    for (int w = 0; w < 8 && !req_ready; w++) @(negedge CLK);
    check("ready_wait", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(negedge CLK);
    req_valid = 1'b0;
    mask = mem_we; maddr = mem_addr; wd = mem_wd; lat = 0;
    for (int c = 1; c <= 5; c++) begin
      if (resp_valid) begin
        lat = c;
        break;
      end
      @(negedge CLK);
    end
    err = resp_err; rdata = resp_rdata;
    @(negedge CLK);
    after = resp_valid;
  endtask

  task automatic do_check(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic e_err, input logic [31:0] e_rdata,
                          input logic [3:0] e_mask, input logic [31:0] e_wd);
    logic err, after;
    logic [31:0] rdata, maddr, wd;
    logic [3:0] mask;
    int lat;
    run_req(we, f3, addr, wdata, err, rdata, mask, maddr, wd, lat, after);
    check({tag, ".err"},     32'(err),  32'(e_err));
    check({tag, ".rdata"},   rdata,     e_rdata);
    check({tag, ".mem_we"},  32'(mask), 32'(e_mask));
    check({tag, ".latency"}, 32'(lat),  e_err ? 32'd1 : 32'd2);
    check({tag, ".pulse"},   32'(after), 32'd0);
    if (we && !e_err) begin
      check({tag, ".mem_addr"}, maddr, {addr[31:2], 2'b00});
      check({tag, ".mem_wd"},   wd,    e_wd);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
    logic [31:0] wd;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_err;
    logic [31:0] r_rdata, r_wd, word;
    logic [3:0]  r_mask;
    logic        rwe;
    logic [2:0]  rf3;
    logic [31:0] raddr, rwdata;
    int          nresp;

    //          we    f3      addr      wdata          err   rdata          mask     wd
    vecs[0]  = '{1'b1, 3'b000, 32'h11, 32'h123456AB, 1'b0, 32'h00000000, 4'b0010, 32'hABABABAB};
    vecs[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'h0000AB00, 4'b0000, 32'h0};
    vecs[2]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'b1111, 32'hDEADBEEF};
    vecs[3]  = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 4'b0000, 32'h0};
    vecs[4]  = '{1'b1, 3'b010, 32'h10, 32'h80FF7F01, 1'b0, 32'h00000000, 4'b1111, 32'h80FF7F01};
    vecs[5]  = '{1'b0, 3'b000, 32'h13, 32'h0,        1'b0, 32'hFFFFFF80, 4'b0000, 32'h0};
    vecs[6]  = '{1'b0, 3'b100, 32'h13, 32'h0,        1'b0, 32'h00000080, 4'b0000, 32'h0};
    vecs[7]  = '{1'b0, 3'b001, 32'h12, 32'h0,        1'b0, 32'hFFFF80FF, 4'b0000, 32'h0};
    vecs[8]  = '{1'b0, 3'b101, 32'h12, 32'h0,        1'b0, 32'h000080FF, 4'b0000, 32'h0};
    vecs[9]  = '{1'b0, 3'b000, 32'h11, 32'h0,        1'b0, 32'h0000007F, 4'b0000, 32'h0};
    vecs[10] = '{1'b0, 3'b010, 32'h06, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[11] = '{1'b1, 3'b001, 32'h03, 32'h1234,     1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[12] = '{1'b0, 3'b011, 32'h10, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[13] = '{1'b1, 3'b001, 32'h12, 32'h0000BEEF, 1'b0, 32'h00000000, 4'b1100, 32'hBEEFBEEF};
    vecs[14] = '{1'b0, 3'b010, 32'h10, 32'h0,        1'b0, 32'hBEEF7F01, 4'b0000, 32'h0};
    vecs[15] = '{1'b1, 3'b100, 32'h10, 32'h5555,     1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[16] = '{1'b0, 3'b001, 32'h11, 32'h0,        1'b1, 32'h00000000, 4'b0000, 32'h0};
    vecs[17] = '{1'b0, 3'b101, 32'h10, 32'h0,        1'b0, 32'h00007F01, 4'b0000, 32'h0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    RESET_N = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge CLK);
    check("rst.req_ready",  32'(req_ready),  32'd1);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.resp_rdata", resp_rdata,      32'd0);
    check("rst.resp_err",   32'(resp_err),   32'd0);
    check("rst.mem_we",     32'(mem_we),     32'd0);
    check("rst.mem_addr",   mem_addr,        32'd0);
    check("rst.mem_wd",     mem_wd,          32'd0);
    RESET_N = 1'b1; mem_clear = 1'b0;
    @(negedge CLK);

    // Directed vectors; the reference memory follows along.
    for (int i = 0; i < NVEC; i++) begin
      ref_access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, r_err, r_rdata, r_mask, r_wd);
      do_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
               vecs[i].err, vecs[i].rdata, vecs[i].mask, vecs[i].wd);
    end

    // Back-to-back loads with req_valid held high: one response every 3 cycles.
    for (int w = 0; w < 8 && !req_ready; w++) @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    nresp = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      check($sformatf("b2b%0d.resp_valid", k), 32'(resp_valid), 32'((k % 3) == 2));
      check($sformatf("b2b%0d.req_ready", k),  32'(req_ready),  32'((k % 3) == 0));
      if (resp_valid) begin
        nresp++;
        check($sformatf("b2b%0d.rdata", k), resp_rdata, 32'hBEEF7F01);
      end
    end
    req_valid = 1'b0;
    check("b2b.count", 32'(nresp), 32'd4);

    // Reset while the response is being presented.
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    check("rdone.resp_valid_before", 32'(resp_valid), 32'd1);
    #1 RESET_N = 1'b0;
    #1 check("rdone.resp_valid_after", 32'(resp_valid), 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("rdone.req_ready", 32'(req_ready), 32'd1);

    // Reset during a store's ACCESS cycle: the write must not commit.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge CLK);
    #1;
    req_valid = 1'b0;
    check("racc.mem_we_before", 32'(mem_we), 32'hF);
    check("racc.mem_addr", mem_addr, 32'h20);
    check("racc.mem_wd", mem_wd, 32'hCAFEF00D);
    #1 RESET_N = 1'b0;
    #1 check("racc.mem_we_after", 32'(mem_we), 32'd0);
    @(negedge CLK);
    check("racc.resp_valid0", 32'(resp_valid), 32'd0);
    @(negedge CLK);
    check("racc.resp_valid1", 32'(resp_valid), 32'd0);
    RESET_N = 1'b1;
    @(negedge CLK);
    check("racc.req_ready", 32'(req_ready), 32'd1);
    check("racc.resp_valid2", 32'(resp_valid), 32'd0);
    check("racc.mem_word", mem[8], 32'h00000000);

    // Randomized requests against the reference model.
    for (int n = 0; n < 300; n++) begin
      rwe    = 1'($urandom_range(0, 1));
      rf3    = 3'($urandom_range(0, 7));
      raddr  = 32'($urandom_range(0, 63));
      rwdata = $urandom;
      ref_access(rwe, rf3, raddr, rwdata, r_err, r_rdata, r_mask, r_wd);
      do_check($sformatf("rnd%0d", n), rwe, rf3, raddr, rwdata, r_err, r_rdata, r_mask, r_wd);
    end

    // Final memory image must match the reference bytes.
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 4; k++) word[8*k +: 8] = ref_mem[10'(4*w + k)];
      check($sformatf("memimg%0d", w), mem[w], word);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
